// File: rtl/fifo_wr_feeder.sv
// Write-side feeder for the async FIFO: 2-entry skid buffer, throttle FSM, sw_rst sequencer.
// Build option FIFO_WR_FEEDER_STATS_EN adds saturating write/stall counters.
module fifo_wr_feeder #(
  parameter int DATA_WIDTH    = 32,
  parameter int LEVEL_WIDTH   = 6,
  parameter int SW_RST_CYCLES = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                   wclk,
  input  logic                   hw_rst,
  input  logic                   s_valid,
  input  logic [DATA_WIDTH-1:0]  s_data,
  input  logic                   s_last,
  output logic                   s_ready,
  input  logic                   sw_rst_req,
  output logic [DATA_WIDTH-1:0]  wdata,
  output logic                   write_enable,
  output logic                   sw_rst,
  input  logic                   wfull,
  input  logic                   wr_almost_ful,
  input  logic [LEVEL_WIDTH-1:0] wr_level,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   words_written,
  output logic [CNT_WIDTH-1:0]   stall_cycles
);

  typedef enum logic [1:0] {
    IDLE, STREAM, THROTTLE, FLUSH
  } state_t;

  localparam int FW =
    (SW_RST_CYCLES > 1) ? $clog2(SW_RST_CYCLES) : 1;
  localparam logic [FW-1:0] FLAST = FW'(SW_RST_CYCLES - 1);

  state_t state, state_nx;
  state_t ret, ret_nx;
  state_t pkt;
  logic [FW-1:0] fcnt, fcnt_nx;

  logic [DATA_WIDTH:0] e0, e1;
  logic [1:0] count;
  logic run;
  logic push, pop;
  logic unused;

  assign s_ready = run && (count != 2'd2) &&
                   (state == IDLE || state == STREAM);
  assign write_enable = (count != 2'd0) && !wfull &&
                        (state != FLUSH);
  assign wdata = (count != 2'd0) ? e0[DATA_WIDTH:1] : '0;
  assign sw_rst = (state == FLUSH);
  assign busy = (state != IDLE) || (count != 2'd0);
  assign push = s_valid && s_ready;
  assign pop = write_enable;

  always_comb begin
    state_nx = state;
    ret_nx = ret;
    fcnt_nx = fcnt;
    pkt = state;
    unique case (1'b1)
      (state == IDLE || state == STREAM): begin
        if (push) pkt = s_last ? IDLE : STREAM;
        if (wr_almost_ful) begin
          state_nx = THROTTLE;
          ret_nx = pkt;
        end else begin
          state_nx = pkt;
        end
      end
      (state == THROTTLE): begin
        if (!wr_almost_ful) state_nx = ret;
      end
      (state == FLUSH): begin
        fcnt_nx = fcnt + 1'b1;
        if (fcnt == FLAST) begin
          state_nx = IDLE;
          fcnt_nx = '0;
        end
      end
    endcase
    // software reset overrides everything, including a re-request mid-flush
    if (sw_rst_req) begin
      state_nx = FLUSH;
      fcnt_nx = '0;
    end
  end

  always_ff @(posedge wclk) begin
    if (!hw_rst) begin
      state <= IDLE;
      ret <= IDLE;
      fcnt <= '0;
      run <= 1'b0;
    end else begin
      state <= state_nx;
      ret <= ret_nx;
      fcnt <= fcnt_nx;
      run <= 1'b1;
    end
  end

  always_ff @(posedge wclk) begin
    if (!hw_rst || sw_rst_req) begin
      count <= 2'd0;
      e0 <= '0;
      e1 <= '0;
    end else begin
      unique case (1'b1)
        (push && pop): begin
          if (count == 2'd1) begin
            e0 <= {s_data, s_last};
          end else begin
            e0 <= e1;
            e1 <= {s_data, s_last};
          end
        end
        (pop && !push): begin
          e0 <= e1;
          count <= count - 2'd1;
        end
        (push && !pop): begin
          if (count == 2'd0) e0 <= {s_data, s_last};
          else e1 <= {s_data, s_last};
          count <= count + 2'd1;
        end
        (!push && !pop): ;
      endcase
    end
  end

`ifdef FIFO_WR_FEEDER_STATS_EN
  logic [CNT_WIDTH-1:0] ww_q, st_q;

  always_ff @(posedge wclk) begin
    if (!hw_rst || sw_rst_req) begin
      ww_q <= '0;
      st_q <= '0;
    end else begin
      if (write_enable && ww_q != '1) ww_q <= ww_q + 1'b1;
      if (count != 2'd0 && wfull && st_q != '1)
        st_q <= st_q + 1'b1;
    end
  end

  assign words_written = ww_q;
  assign stall_cycles = st_q;
`else
  assign words_written = '0;
  assign stall_cycles = '0;
`endif

  // the level and the head's last flag have no consumer here
  assign unused = ^{wr_level, e0[0]};

endmodule

// File: tb/tb_fifo_wr_feeder.sv
// Randomized bench for fifo_wr_feeder against a queue-based packet model.
// Honors FIFO_WR_FEEDER_STATS_EN for the counter expectations.
module tb_fifo_wr_feeder;

  localparam int DW = 32;
  localparam int LW = 6;
  localparam int NR = 4;
  localparam int CW = 16;
  localparam int NCYC = 4000;

  logic wclk = 1'b0;
  logic hw_rst, s_valid, s_last, sw_rst_req;
  logic wfull, wr_almost_ful;
  logic [DW-1:0] s_data;
  logic [LW-1:0] wr_level;
  logic s_ready, write_enable, sw_rst, busy;
  logic [DW-1:0] wdata;
  logic [CW-1:0] words_written, stall_cycles;

  fifo_wr_feeder #(
    .DATA_WIDTH(DW), .LEVEL_WIDTH(LW),
    .SW_RST_CYCLES(NR), .CNT_WIDTH(CW)
  ) dut (
    .wclk(wclk), .hw_rst(hw_rst),
    .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(s_ready),
    .sw_rst_req(sw_rst_req), .wdata(wdata),
    .write_enable(write_enable), .sw_rst(sw_rst),
    .wfull(wfull), .wr_almost_ful(wr_almost_ful),
    .wr_level(wr_level), .busy(busy),
    .words_written(words_written),
    .stall_cycles(stall_cycles)
  );

  always #5 wclk = ~wclk;

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // model: queued words, packet/throttle flags, remaining flush cycles
  logic [DW-1:0] q[$];
  bit alive, in_pkt, thr;
  int flush_left;
  int ww, st;

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  initial begin
    bit r_exp, we_exp, push, pop;
    int wf_pct;
    hw_rst = 1'b0;
    s_valid = 1'b1;
    s_data = '0;
    s_last = 1'b0;
    sw_rst_req = 1'b0;
    wfull = 1'b0;
    wr_almost_ful = 1'b0;
    wr_level = '0;
    alive = 0; in_pkt = 0; thr = 0;
    flush_left = 0; ww = 0; st = 0;
    @(posedge wclk);
    for (int c = 0; c < NCYC; c++) begin
      @(negedge wclk);
      wf_pct = (c / 500) % 4 * 25;
      hw_rst = (c < 3) ? 1'b0 :
               ($urandom_range(999) != 0);
      s_valid = (c < 3) ? 1'b1 : ($urandom_range(3) != 0);
      s_data = $urandom;
      s_last = ($urandom_range(5) == 0);
      sw_rst_req = ($urandom_range(79) == 0);
      wfull = ($urandom_range(99) < wf_pct);
      if ($urandom_range(24) == 0)
        wr_almost_ful = ~wr_almost_ful;
      wr_level = LW'($urandom);
      #1;
      r_exp = alive && q.size() < 2 && !thr &&
              flush_left == 0;
      we_exp = q.size() > 0 && !wfull && flush_left == 0;
      chk("s_ready", 64'(s_ready), 64'(r_exp));
      chk("write_enable", 64'(write_enable), 64'(we_exp));
      chk("wdata", 64'(wdata),
          64'(q.size() > 0 ? q[0] : '0));
      chk("sw_rst", 64'(sw_rst), 64'(flush_left > 0));
      chk("busy", 64'(busy),
          64'(in_pkt || thr || flush_left > 0 || q.size() > 0));
`ifdef FIFO_WR_FEEDER_STATS_EN
      chk("words_written", 64'(words_written), 64'(ww));
      chk("stall_cycles", 64'(stall_cycles), 64'(st));
`else
      chk("words_written", 64'(words_written), 64'd0);
      chk("stall_cycles", 64'(stall_cycles), 64'd0);
`endif
      push = s_valid && r_exp;
      pop = we_exp;
      if (!hw_rst) begin
        q.delete();
        alive = 0; in_pkt = 0; thr = 0;
        flush_left = 0; ww = 0; st = 0;
      end else if (sw_rst_req) begin
        q.delete();
        alive = 1; in_pkt = 0; thr = 0;
        flush_left = NR; ww = 0; st = 0;
      end else begin
        if (q.size() > 0 && wfull) st = sat(st + 1);
        if (pop) begin
          void'(q.pop_front());
          ww = sat(ww + 1);
        end
        if (push) q.push_back(s_data);
        if (flush_left > 0) begin
          flush_left--;
        end else if (!thr) begin
          if (push) in_pkt = !s_last;
          if (wr_almost_ful) thr = 1;
        end else if (!wr_almost_ful) begin
          thr = 0;
        end
        alive = 1;
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
